// File: rtl/i2s_audio_sched.sv
// rtl/i2s_audio_sched.sv - Philips I2S transmitter with one-entry sample buffer and underrun counting
module i2s_audio_sched #(
  parameter int HALF_DIV = 18,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mute,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                hp_bck,
  output logic                hp_ws,
  output logic                hp_din,
  output logic                frame_strobe,
  output logic [7:0]          underrun_cnt
);
  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SAMPLE_W - 1);
  localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FRAME_W - 2);
  localparam logic [7:0]       DIV_LAST = 8'(HALF_DIV - 1);

  logic [7:0]         div_cnt;
  logic               bck;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_nxt;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] frame_nxt;
  logic [FRAME_W-1:0] frame_shift;
  logic [FRAME_W-1:0] pending;
  logic               pend_valid;
  logic               tick;
  logic               fall_tick;
  logic               load;
  logic               accept;
  logic               ws_nxt;

  assign tick      = (div_cnt == DIV_LAST);
  assign fall_tick = tick & bck;
  assign load      = fall_tick & (bit_cnt == LAST_BIT);
  assign s_ready   = enable & ~pend_valid;
  assign accept    = s_valid & s_ready;
  assign hp_bck    = bck;

  // Pin registers are fed from next-state values so data and WS move on the same edge as BCK falls.
  always_comb begin
    bit_nxt   = bit_cnt;
    frame_nxt = frame;
    if (fall_tick) begin
      bit_nxt = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
    end
    if (load) begin
      frame_nxt = (pend_valid && !mute) ? pending : '0;
    end
    frame_shift = frame_nxt << bit_nxt;
    ws_nxt      = (bit_nxt >= WS_FIRST) && (bit_nxt <= WS_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt      <= '0;
      bck          <= 1'b0;
      bit_cnt      <= LAST_BIT;
      frame        <= '0;
      pending      <= '0;
      pend_valid   <= 1'b0;
      underrun_cnt <= '0;
      hp_ws        <= 1'b0;
      hp_din       <= 1'b0;
      frame_strobe <= 1'b0;
    end else if (!enable) begin
      // Halt flushes the frame and the pending sample but keeps the underrun history.
      div_cnt      <= '0;
      bck          <= 1'b0;
      bit_cnt      <= LAST_BIT;
      frame        <= '0;
      pend_valid   <= 1'b0;
      hp_ws        <= 1'b0;
      hp_din       <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + 8'd1;
      if (tick) begin
        bck <= ~bck;
      end
      bit_cnt      <= bit_nxt;
      frame        <= frame_nxt;
      hp_ws        <= ws_nxt;
      hp_din       <= frame_shift[FRAME_W-1];
      frame_strobe <= load;
      // An accept can only coincide with a load when the buffer was empty, so it wins.
      if (accept) begin
        pending    <= {s_left, s_right};
        pend_valid <= 1'b1;
      end else if (load) begin
        pend_valid <= 1'b0;
      end
      if (load && !pend_valid && underrun_cnt != 8'hFF) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end
endmodule
